// File: rtl/divisor4_sequencer.sv
// divisor4_sequencer: multi-cycle 4/4-bit restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     - operand handshake; a (dividend) and b (divisor) are sampled on accept
//   abort                 - cancels a calculation in progress; the previous result is kept
//   out_valid/out_ready   - result handshake; q/r/err are held while out_valid && !out_ready
//   q, r, err             - quotient, remainder, divide-by-zero flag (registered)
//   busy                  - high while calculating or holding an unconsumed result
module divisor4_sequencer #(
    parameter logic [3:0] ERR_Q = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       err,
    output logic       busy
);

    localparam int unsigned W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   dividend, dividend_nxt;
    logic [W-1:0]   divisor, divisor_nxt;
    logic [W-1:0]   quot, quot_nxt;
    // The partial remainder is always below the divisor, so only its low W bits are stored;
    // the shift/compare/subtract stage below still works at W+1 bits.
    logic [W-1:0]   rem, rem_nxt;
    logic [1:0]     cnt, cnt_nxt;
    logic [W-1:0]   q_nxt, r_nxt;
    logic           err_nxt;

    logic [W:0]     shifted;
    logic           ge;
    logic [W-1:0]   rem_step;
    logic [W-1:0]   quot_step;

    // Shared compare/subtract stage for the current quotient bit
    always_comb begin
        shifted   = {rem, dividend[cnt]};
        ge        = (shifted >= {1'b0, divisor});
        rem_step  = ge ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];
        quot_step = quot | (W'(ge) << cnt);
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt    = state;
        dividend_nxt = dividend;
        divisor_nxt  = divisor;
        quot_nxt     = quot;
        rem_nxt      = rem;
        cnt_nxt      = cnt;
        q_nxt        = q;
        r_nxt        = r;
        err_nxt      = err;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    dividend_nxt = a;
                    divisor_nxt  = b;
                    quot_nxt     = '0;
                    rem_nxt      = '0;
                    cnt_nxt      = 2'd3;
                    if (b == '0) begin
                        state_nxt = DONE;
                        q_nxt     = ERR_Q;
                        r_nxt     = a;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (abort) begin
                    // Discard partial work; last delivered result stays on q/r/err
                    state_nxt = IDLE;
                    quot_nxt  = '0;
                    rem_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    quot_nxt = quot_step;
                    rem_nxt  = rem_step;
                    if (cnt == 2'd0) begin
                        state_nxt = DONE;
                        q_nxt     = quot_step;
                        r_nxt     = rem_step;
                        err_nxt   = 1'b0;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dividend  <= '0;
            divisor   <= '0;
            quot      <= '0;
            rem       <= '0;
            cnt       <= '0;
            q         <= '0;
            r         <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dividend  <= dividend_nxt;
            divisor   <= divisor_nxt;
            quot      <= quot_nxt;
            rem       <= rem_nxt;
            cnt       <= cnt_nxt;
            q         <= q_nxt;
            r         <= r_nxt;
            err       <= err_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule
